// File: rtl/counter_mod_updown.sv
// Up/down modulus counter with prescaler, parallel load, wrap/saturate and tc pulse.
// Define COUNTER_STICKY_OVF_EN to add the sticky ovf_flag/ovf_clr pair.
`timescale 1ns/1ps
module counter_mod_updown #(
    parameter int WIDTH     = 8,
    parameter int MOD_VALUE = 256,
    parameter int PRESCALE  = 1,
    parameter int SATURATE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef COUNTER_STICKY_OVF_EN
    output logic             ovf_flag,
    input  logic             ovf_clr,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD_VALUE - 1);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
    localparam bit SAT = (SATURATE != 0);

    if (WIDTH < 1) begin : g_bad_width
        $error("counter_mod_updown: WIDTH must be >= 1");
    end
    if (MOD_VALUE < 2 || (WIDTH < 31 && MOD_VALUE > (1 << WIDTH))) begin : g_bad_mod
        $error("counter_mod_updown: MOD_VALUE out of range");
    end
    if (PRESCALE < 1) begin : g_bad_pre
        $error("counter_mod_updown: PRESCALE must be >= 1");
    end
    if (SATURATE != 0 && SATURATE != 1) begin : g_bad_sat
        $error("counter_mod_updown: SATURATE must be 0 or 1");
    end

    logic [PW-1:0]    pre;
    logic [PW-1:0]    pre_nxt;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] q_load;
    logic             step;
    logic             at_bnd;
    logic             bnd_evt;

    assign step    = en && (pre == PMAX);
    assign at_bnd  = up_dn ? (q == MAXV) : (q == '0);
    assign bnd_evt = !load && step && at_bnd;
    assign pre_nxt = (pre == PMAX) ? '0 : pre + 1'b1;
    assign q_load  = (load_val > MAXV) ? MAXV : load_val;

    // Boundary either wraps to the opposite end or holds in saturate mode.
    always_comb begin
        q_step = q;
        if (up_dn) begin
            if (q != MAXV)
                q_step = q + 1'b1;
            else if (!SAT)
                q_step = '0;
        end else begin
            if (q != '0)
                q_step = q - 1'b1;
            else if (!SAT)
                q_step = MAXV;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            tc  <= 1'b0;
            pre <= '0;
        end else if (load) begin
            q   <= q_load;
            tc  <= 1'b0;
            pre <= '0;
        end else begin
            tc <= bnd_evt;
            if (en)
                pre <= pre_nxt;
            if (step)
                q <= q_step;
        end
    end

`ifdef COUNTER_STICKY_OVF_EN
    // A boundary event in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst)
            ovf_flag <= 1'b0;
        else if (bnd_evt)
            ovf_flag <= 1'b1;
        else if (ovf_clr)
            ovf_flag <= 1'b0;
    end
`endif

endmodule
